// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irqState_t;

  localparam int NUM_SRC_DEFAULT = 8;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-wins priority encoder with a valid flag.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] reqVec,
  output logic [ID_W-1:0]    winnerId,
  output logic               winnerValid
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    winnerId    = '0;
    winnerValid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        winnerId    = ID_W'(i);
        winnerValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending/mask registers, priority pick, REQUEST/SERVICE handshake.
// Optional sticky overflow flags are built when IRQ_OVERFLOW_EN is defined.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  localparam int ID_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irqSrc,
  input  logic [NUM_SRC-1:0] maskIn,
  input  logic               maskWe,
  input  logic [NUM_SRC-1:0] pendClrIn,
  input  logic               pendClrWe,
  input  logic               irqAck,
  input  logic               irqEoi,
`ifdef IRQ_OVERFLOW_EN
  input  logic               overflowClrWe,
  output logic [NUM_SRC-1:0] overflowOut,
`endif
  output logic               irqOut,
  output logic [ID_W-1:0]    irqId,
  output logic               activeOut,
  output logic [NUM_SRC-1:0] pendingOut,
  output logic [NUM_SRC-1:0] maskOut
);

  irqState_t          stateReg, stateNext;
  logic [ID_W-1:0]    idReg, idNext;
  logic [NUM_SRC-1:0] pendingReg, pendingNext;
  logic [NUM_SRC-1:0] maskReg;
  logic [NUM_SRC-1:0] srcPrevReg;
  logic [NUM_SRC-1:0] srcEdge;
  logic [NUM_SRC-1:0] ackClr;
  logic [NUM_SRC-1:0] clrVec;
  logic [ID_W-1:0]    winnerId;
  logic               winnerValid;
  logic               ackFire;

  assign srcEdge = irqSrc & ~srcPrevReg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gAckClr
      assign ackClr[gi] = ackFire && (idReg == ID_W'(gi));
    end
  endgenerate

  // New edges are OR-ed in last so a set always beats a same-cycle clear.
  assign clrVec      = (pendClrWe ? pendClrIn : '0) | ackClr;
  assign pendingNext = (pendingReg & ~clrVec) | srcEdge;

  irq_priority_encoder #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) uPrio (
    .reqVec      (pendingReg & maskReg),
    .winnerId    (winnerId),
    .winnerValid (winnerValid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg   <= IDLE;
      idReg      <= '0;
      pendingReg <= '0;
      maskReg    <= '0;
      srcPrevReg <= '0;
    end else begin
      stateReg   <= stateNext;
      idReg      <= idNext;
      pendingReg <= pendingNext;
      srcPrevReg <= irqSrc;
      if (maskWe) maskReg <= maskIn;
    end
  end

  always_comb begin
    stateNext = stateReg;
    idNext    = idReg;
    ackFire   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (winnerValid) begin
          idNext    = winnerId;
          stateNext = REQUEST;
        end
      end
      REQUEST: begin
        // Acknowledge wins over a same-cycle withdrawal.
        if (irqAck) begin
          ackFire   = 1'b1;
          stateNext = SERVICE;
        end else if (!(pendingReg[idReg] && maskReg[idReg])) begin
          stateNext = IDLE;
        end
      end
      SERVICE: begin
        if (irqEoi) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef IRQ_OVERFLOW_EN
  logic [NUM_SRC-1:0] overflowReg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflowReg <= '0;
    end else begin
      overflowReg <= (overflowClrWe ? '0 : overflowReg) | (srcEdge & pendingReg & ~clrVec);
    end
  end

  assign overflowOut = overflowReg;
`endif

  assign irqOut     = (stateReg == REQUEST);
  assign activeOut  = (stateReg == SERVICE);
  assign irqId      = idReg;
  assign pendingOut = pendingReg;
  assign maskOut    = maskReg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed table-driven bench for irq_controller (NUM_SRC = 8), plus reset and overflow sequences.
module tb_irq_controller;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irqSrc, maskIn, pendClrIn;
  logic       maskWe, pendClrWe, irqAck, irqEoi;
  logic       irqOut, activeOut;
  logic [2:0] irqId;
  logic [7:0] pendingOut, maskOut;
`ifdef IRQ_OVERFLOW_EN
  logic       overflowClrWe;
  logic [7:0] overflowOut;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irqSrc     (irqSrc),
    .maskIn     (maskIn),
    .maskWe     (maskWe),
    .pendClrIn  (pendClrIn),
    .pendClrWe  (pendClrWe),
    .irqAck     (irqAck),
    .irqEoi     (irqEoi),
`ifdef IRQ_OVERFLOW_EN
    .overflowClrWe (overflowClrWe),
    .overflowOut   (overflowOut),
`endif
    .irqOut     (irqOut),
    .irqId      (irqId),
    .activeOut  (activeOut),
    .pendingOut (pendingOut),
    .maskOut    (maskOut)
  );

  typedef struct {
    logic [7:0] src;
    logic [7:0] mIn;
    logic       mWe;
    logic [7:0] cIn;
    logic       cWe;
    logic       ack;
    logic       eoi;
    logic       eIrq;
    logic [2:0] eId;
    logic       eAct;
    logic [7:0] ePend;
    logic [7:0] eMask;
  } vec_t;

  vec_t vecs[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    irqSrc = '0; maskIn = '0; maskWe = 1'b0; pendClrIn = '0; pendClrWe = 1'b0;
    irqAck = 1'b0; irqEoi = 1'b0;
`ifdef IRQ_OVERFLOW_EN
    overflowClrWe = 1'b0;
`endif
  endtask

  initial begin
    //         src    mIn    mWe cIn    cWe ack eoi  irq id   act pend   mask
    vecs[0]  = '{8'h00, 8'hFF, 1, 8'h00, 0, 0, 0,   0, 3'd0, 0, 8'h00, 8'hFF};
    vecs[1]  = '{8'h08, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd0, 0, 8'h08, 8'hFF};
    vecs[2]  = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd3, 0, 8'h08, 8'hFF};
    vecs[3]  = '{8'h00, 8'h00, 0, 8'h00, 0, 1, 0,   0, 3'd3, 1, 8'h00, 8'hFF};
    vecs[4]  = '{8'h00, 8'h00, 0, 8'h00, 0, 1, 0,   0, 3'd3, 1, 8'h00, 8'hFF};
    vecs[5]  = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 1,   0, 3'd3, 0, 8'h00, 8'hFF};
    vecs[6]  = '{8'h24, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd3, 0, 8'h24, 8'hFF};
    vecs[7]  = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd2, 0, 8'h24, 8'hFF};
    vecs[8]  = '{8'h00, 8'h00, 0, 8'h00, 0, 1, 0,   0, 3'd2, 1, 8'h20, 8'hFF};
    vecs[9]  = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 1,   0, 3'd2, 0, 8'h20, 8'hFF};
    vecs[10] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd5, 0, 8'h20, 8'hFF};
    vecs[11] = '{8'h00, 8'h00, 0, 8'h00, 0, 1, 0,   0, 3'd5, 1, 8'h00, 8'hFF};
    vecs[12] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 1,   0, 3'd5, 0, 8'h00, 8'hFF};
    vecs[13] = '{8'h02, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd5, 0, 8'h02, 8'hFF};
    vecs[14] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd1, 0, 8'h02, 8'hFF};
    vecs[15] = '{8'h02, 8'h00, 0, 8'h02, 1, 0, 0,   1, 3'd1, 0, 8'h02, 8'hFF};
    vecs[16] = '{8'h00, 8'h00, 0, 8'h02, 1, 0, 0,   1, 3'd1, 0, 8'h00, 8'hFF};
    vecs[17] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd1, 0, 8'h00, 8'hFF};
    vecs[18] = '{8'h00, 8'h00, 0, 8'h00, 0, 1, 1,   0, 3'd1, 0, 8'h00, 8'hFF};
    vecs[19] = '{8'h01, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd1, 0, 8'h01, 8'hFF};
    vecs[20] = '{8'h01, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd0, 0, 8'h01, 8'hFF};
    vecs[21] = '{8'h01, 8'h00, 0, 8'h00, 0, 1, 0,   0, 3'd0, 1, 8'h00, 8'hFF};
    vecs[22] = '{8'h01, 8'h00, 0, 8'h00, 0, 0, 1,   0, 3'd0, 0, 8'h00, 8'hFF};
    vecs[23] = '{8'h01, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd0, 0, 8'h00, 8'hFF};
    vecs[24] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd0, 0, 8'h00, 8'hFF};
    vecs[25] = '{8'h10, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd0, 0, 8'h10, 8'hFF};
    vecs[26] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd4, 0, 8'h10, 8'hFF};
    vecs[27] = '{8'h00, 8'hEF, 1, 8'h00, 0, 0, 0,   1, 3'd4, 0, 8'h10, 8'hEF};
    vecs[28] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd4, 0, 8'h10, 8'hEF};
    vecs[29] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   0, 3'd4, 0, 8'h10, 8'hEF};
    vecs[30] = '{8'h00, 8'hFF, 1, 8'h00, 0, 0, 0,   0, 3'd4, 0, 8'h10, 8'hFF};
    vecs[31] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3'd4, 0, 8'h10, 8'hFF};
    vecs[32] = '{8'h00, 8'h00, 0, 8'h10, 1, 1, 0,   0, 3'd4, 1, 8'h00, 8'hFF};
    vecs[33] = '{8'h00, 8'h00, 0, 8'h00, 0, 0, 1,   0, 3'd4, 0, 8'h00, 8'hFF};

    clearInputs();
    reset = 1'b0;
    step();
    step();
    check("reset irqOut", 32'(irqOut), 32'd0);
    check("reset activeOut", 32'(activeOut), 32'd0);
    check("reset irqId", 32'(irqId), 32'd0);
    check("reset pending", 32'(pendingOut), 32'd0);
    check("reset mask", 32'(maskOut), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 34; v++) begin
      irqSrc = vecs[v].src; maskIn = vecs[v].mIn; maskWe = vecs[v].mWe;
      pendClrIn = vecs[v].cIn; pendClrWe = vecs[v].cWe;
      irqAck = vecs[v].ack; irqEoi = vecs[v].eoi;
      step();
      check($sformatf("vec%0d irqOut", v), 32'(irqOut), 32'(vecs[v].eIrq));
      check($sformatf("vec%0d irqId", v), 32'(irqId), 32'(vecs[v].eId));
      check($sformatf("vec%0d activeOut", v), 32'(activeOut), 32'(vecs[v].eAct));
      check($sformatf("vec%0d pending", v), 32'(pendingOut), 32'(vecs[v].ePend));
      check($sformatf("vec%0d mask", v), 32'(maskOut), 32'(vecs[v].eMask));
      $display("vec %0d: irqOut=%0b irqId=%0d active=%0b pending=%h mask=%h",
               v, irqOut, irqId, activeOut, pendingOut, maskOut);
    end
    clearInputs();

    // Reset in the middle of SERVICE, then a stray EOI.
    irqSrc = 8'h40; step();
    irqSrc = 8'h00; step();
    check("rst seq request", 32'(irqOut), 32'd1);
    check("rst seq id", 32'(irqId), 32'd6);
    irqAck = 1'b1; step();
    irqAck = 1'b0;
    check("rst seq service", 32'(activeOut), 32'd1);
    reset = 1'b0; step();
    check("rst mid irqOut", 32'(irqOut), 32'd0);
    check("rst mid activeOut", 32'(activeOut), 32'd0);
    check("rst mid irqId", 32'(irqId), 32'd0);
    check("rst mid pending", 32'(pendingOut), 32'd0);
    check("rst mid mask", 32'(maskOut), 32'd0);
    reset = 1'b1;
    irqEoi = 1'b1; step();
    irqEoi = 1'b0;
    check("post rst eoi active", 32'(activeOut), 32'd0);
    check("post rst eoi irqOut", 32'(irqOut), 32'd0);
    $display("reset seq: irqOut=%0b active=%0b irqId=%0d", irqOut, activeOut, irqId);

`ifdef IRQ_OVERFLOW_EN
    maskIn = 8'hFF; maskWe = 1'b1; step();
    maskWe = 1'b0;
    irqSrc = 8'h01; step();
    check("ovf after first edge", 32'(overflowOut), 32'd0);
    irqSrc = 8'h00; step();
    irqSrc = 8'h01; step();
    check("ovf after second edge", 32'(overflowOut), 32'h01);
    irqSrc = 8'h00; overflowClrWe = 1'b1; step();
    overflowClrWe = 1'b0;
    check("ovf cleared", 32'(overflowOut), 32'd0);
    $display("overflow seq: overflowOut=%h", overflowOut);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter SHALL be NUM_SRC, default 8, number of interrupt sources (2..32); ID_W = $clog2(NUM_SRC).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-004 irqSrc  input  NUM_SRC  interrupt request lines from peripheral cores (a pulse of one cycle or longer).
REQ-005 maskIn / maskWe  input  NUM_SRC / 1  enable-mask write data and strobe (1 = source enabled).
REQ-006 pendClrIn / pendClrWe  input  NUM_SRC / 1  write-1-to-clear pending data and strobe.
REQ-007 irqAck  input  1  CPU acknowledge, one-cycle pulse.
REQ-008 irqEoi  input  1  CPU end-of-interrupt, one-cycle pulse.
REQ-009 irqOut  output  1  interrupt request to CPU.
REQ-010 irqId  output  ID_W  index of the requested or in-service source.
REQ-011 activeOut  output  1  high while an interrupt is in service.
REQ-012 pendingOut / maskOut  output  NUM_SRC each  pending and mask register readback.

Function
REQ-013 Rising-edge detect SHALL be srcEdge = irqSrc & ~srcPrev; srcPrev registers irqSrc every cycle.
REQ-014 pending SHALL be updated as (pending & ~clr) | srcEdge; clr = pendClrIn when pendClrWe, plus the ack clear of REQ-018; a set wins over any clear on the same bit in the same cycle.
REQ-015 Eligible set = pending & mask; winner = lowest-index eligible bit.
REQ-016 FSM states SHALL be IDLE, REQUEST, SERVICE.
REQ-017 IDLE: if eligible set non-zero, latch winner into irqId and go to REQUEST; otherwise stay.
REQ-018 REQUEST: irqOut = 1, irqId held stable; on irqAck clear pending[irqId] and go to SERVICE.
REQ-019 REQUEST withdrawal: if pending[irqId] & mask[irqId] becomes 0 without irqAck, go to IDLE; irqOut drops the next cycle; a same-cycle irqAck takes precedence.
REQ-020 SERVICE: irqOut = 0, activeOut = 1, irqId held; on irqEoi go to IDLE; no nesting or preemption.
REQ-021 irqAck outside REQUEST and irqEoi outside SERVICE SHALL be ignored.
REQ-022 Latency: edge sampled at clock k sets pending at k; irqOut high after k+1 (two-cycle latency from IDLE).
REQ-023 After EOI, a still-eligible source SHALL be requested after the next clock, so back-to-back latency is one IDLE cycle.
REQ-024 A mask write SHALL take effect for eligibility the cycle after maskWe.
REQ-025 A source that is held high produces one pending event; it must fall and rise again to re-pend.

Reset
REQ-026 On reset low at a clock edge: state = IDLE; pending, mask, srcPrev = 0; irqOut, activeOut = 0; irqId = 0; overflow = 0.
REQ-027 Reset mid-REQUEST or mid-SERVICE SHALL abandon the transaction with no ack/EOI required afterwards.

Configuration
REQ-028 Macro IRQ_OVERFLOW_EN SHALL, when defined, add output overflowOut (NUM_SRC) and input overflowClrWe (1).
REQ-029 With IRQ_OVERFLOW_EN, overflow[i] SHALL set when srcEdge[i] arrives while pending[i] = 1 and is not cleared that cycle; overflowClrWe clears all; a set wins over a clear.
REQ-030 Without IRQ_OVERFLOW_EN, the ports and logic SHALL be absent, and the remaining behaviour is identical.

Structure
REQ-031 Package irq_pkg SHALL hold the irqState_t enum (IDLE, REQUEST, SERVICE) and the NUM_SRC_DEFAULT constant.
REQ-032 Sub-module irq_priority_encoder SHALL map NUM_SRC vector to lowest set index plus a valid bit.

Verification
REQ-033 Mask = 0xFF, pulse irqSrc[3] one cycle -> irqOut high 2 cycles later, irqId = 3; ack -> activeOut = 1, pending[3] = 0; EOI -> IDLE.
REQ-034 Sources 5 and 2 rise in the same cycle -> irqId = 2 first; after ack+EOI, irqId = 5 one idle cycle later.
REQ-035 In REQUEST for source 4, write maskIn = 0xEF -> irqOut drops, state IDLE, pending[4] remains 1; re-enable -> request reappears.
REQ-036 Same-cycle pendClrWe with bit 1 set and a new edge on irqSrc[1] -> pending[1] = 1.
REQ-037 Reset low during SERVICE -> all outputs 0 on next cycle; subsequent EOI is ignored.
REQ-038 IRQ_OVERFLOW_EN defined: two edges on irqSrc[0] with no ack -> overflowOut[0] = 1; overflowClrWe -> 0.
